// File: rtl/resolvedor_pkg.sv
// Shared definitions for the execute-stage branch resolver: B-type funct3 codes,
// handshake state encoding and the illegal-funct3 helper.
package resolvedor_pkg;

   localparam int XLEN_DEF    = 32;
   localparam int PC_STEP_DEF = 4;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic {
      VACIO = 1'b0,
      LLENO = 1'b1
   } estado_t;

   // 010 and 011 are the only B-type encodings with no branch meaning
   function automatic logic es_ilegal(input logic [2:0] f3);
      return (f3[2:1] == 2'b01);
   endfunction

endpackage

// File: rtl/comparador_rama.sv
// Combinational operand comparator for the branch resolver: equality,
// signed less-than and unsigned less-than of two XLEN-wide operands.
module comparador_rama #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_eq,
   output logic            o_lt,
   output logic            o_ltu
);

   assign o_eq  = (i_a == i_b);
   assign o_lt  = ($signed(i_a) < $signed(i_b));
   assign o_ltu = (i_a < i_b);

endmodule

// File: rtl/resolvedor_saltos.sv
// Branch resolver: accepts one conditional branch per valid/ready handshake and returns
// a registered taken/next-PC result one cycle later. Define BRANCH_STATS_EN for outcome counters.
module resolvedor_saltos
   import resolvedor_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int PC_STEP = PC_STEP_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   output logic            res_valid,
   input  logic            res_ready,
   output logic            res_taken,
   output logic [XLEN-1:0] res_pc,
   output logic            res_illegal,
   output logic            res_misalign
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     cnt_taken,
   output logic [31:0]     cnt_not_taken
`endif
);

   estado_t         r_estado;
   logic            r_taken;
   logic [XLEN-1:0] r_pc;
   logic            r_illegal;
   logic            r_misalign;

   logic            w_eq;
   logic            w_lt;
   logic            w_ltu;
   logic            w_accept;
   logic            w_taken;
   logic            w_illegal;
   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_seqPc;

   comparador_rama #(.XLEN(XLEN)) u_comparador (
      .i_a   (rs1_val),
      .i_b   (rs2_val),
      .o_eq  (w_eq),
      .o_lt  (w_lt),
      .o_ltu (w_ltu)
   );

   // A held result blocks new requests unless fetch drains it in the same cycle
   assign in_ready  = !flush && ((r_estado == VACIO) || res_ready);
   assign w_accept  = in_valid && in_ready;
   assign w_target  = pc + imm;
   assign w_seqPc   = pc + XLEN'(PC_STEP);
   assign w_illegal = es_ilegal(funct3);

   always_comb begin
      w_taken = 1'b0;
      case (funct3)
         F3_BEQ:  w_taken = w_eq;
         F3_BNE:  w_taken = !w_eq;
         F3_BLT:  w_taken = w_lt;
         F3_BGE:  w_taken = !w_lt;
         F3_BLTU: w_taken = w_ltu;
         F3_BGEU: w_taken = !w_ltu;
         default: w_taken = 1'b0;
      endcase
   end

   // Result fields only move on accept; flush merely drops the valid state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_estado   <= VACIO;
         r_taken    <= 1'b0;
         r_pc       <= '0;
         r_illegal  <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         if (w_accept) begin
            r_taken    <= w_taken;
            r_pc       <= w_taken ? w_target : w_seqPc;
            r_illegal  <= w_illegal;
            r_misalign <= w_taken && (w_target[1:0] != 2'b00);
         end
         if (flush)
            r_estado <= VACIO;
         else if (w_accept)
            r_estado <= LLENO;
         else if (res_ready)
            r_estado <= VACIO;
      end
   end

   assign res_valid    = (r_estado == LLENO);
   assign res_taken    = r_taken;
   assign res_pc       = r_pc;
   assign res_illegal  = r_illegal;
   assign res_misalign = r_misalign;

`ifdef BRANCH_STATS_EN
   logic [31:0] r_cntTaken;
   logic [31:0] r_cntNotTaken;

   // A result killed by flush in its handshake cycle never reaches fetch, so it is not counted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cntTaken    <= '0;
         r_cntNotTaken <= '0;
      end else if (res_valid && res_ready && !flush) begin
         if (r_taken)
            r_cntTaken <= r_cntTaken + 32'd1;
         else
            r_cntNotTaken <= r_cntNotTaken + 32'd1;
      end
   end

   assign cnt_taken     = r_cntTaken;
   assign cnt_not_taken = r_cntNotTaken;
`endif

endmodule

// File: tb/tb_resolvedor_saltos.sv
// Scoreboard bench for resolvedor_saltos: directed and random branches, expected results
// from a behavioural model queued on accept and popped by a monitor on result handshakes.
module tb_resolvedor_saltos;

   typedef struct packed {
      logic        taken;
      logic        illegal;
      logic        misalign;
      logic [31:0] pc;
   } expT;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  funct3;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] pc;
   logic [31:0] imm;
   logic        res_valid;
   logic        res_ready;
   logic        res_taken;
   logic [31:0] res_pc;
   logic        res_illegal;
   logic        res_misalign;
`ifdef BRANCH_STATS_EN
   logic [31:0] cnt_taken;
   logic [31:0] cnt_not_taken;
   int unsigned modelTaken;
   int unsigned modelNotTaken;
`endif

   expT expQ[$];
   int  checks;
   int  failures;

   resolvedor_saltos #(.XLEN(32), .PC_STEP(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .funct3       (funct3),
      .rs1_val      (rs1_val),
      .rs2_val      (rs2_val),
      .pc           (pc),
      .imm          (imm),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_taken    (res_taken),
      .res_pc       (res_pc),
      .res_illegal  (res_illegal),
      .res_misalign (res_misalign)
`ifdef BRANCH_STATS_EN
      ,
      .cnt_taken     (cnt_taken),
      .cnt_not_taken (cnt_not_taken)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: branch rules evaluated with wide integer arithmetic
   function automatic expT model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] p, input logic [31:0] im);
      expT         e;
      longint      sa;
      longint      sb;
      longint      ua;
      longint      ub;
      longint      tgt;
      logic        t;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      e.illegal = 1'b0;
      case (f3)
         3'd0:    t = (ua == ub);
         3'd1:    t = (ua != ub);
         3'd4:    t = (sa < sb);
         3'd5:    t = (sa >= sb);
         3'd6:    t = (ua < ub);
         3'd7:    t = (ua >= ub);
         default: begin t = 1'b0; e.illegal = 1'b1; end
      endcase
      tgt = (longint'({32'd0, p}) + longint'({32'd0, im})) % 64'sd4294967296;
      e.taken    = t;
      e.pc       = t ? 32'(tgt) : 32'((longint'({32'd0, p}) + 4) % 64'sd4294967296);
      e.misalign = t && ((tgt % 4) != 0);
      return e;
   endfunction

   // Drive one cycle of inputs, then record what the bench expects the DUT to have accepted
   task automatic applyStimulus(input logic v, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] p, input logic [31:0] im,
                                input logic rr, input logic fl, input logic rs);
      logic expRdy;
      @(posedge clk);
      #1;
      in_valid  = v;
      funct3    = f3;
      rs1_val   = a;
      rs2_val   = b;
      pc        = p;
      imm       = im;
      res_ready = rr;
      flush     = fl;
      rst       = rs;
      @(negedge clk);
      #1;
      if (rs) begin
         expQ.delete();
`ifdef BRANCH_STATS_EN
         modelTaken    = 0;
         modelNotTaken = 0;
`endif
      end else begin
         expRdy = !fl && ((expQ.size() == 0) || rr);
         checks++;
         if (in_ready !== expRdy) begin
            failures++;
            $display("[TB] FAIL in_ready: got %b, expected %b at %0t", in_ready, expRdy, $time);
         end
         if (fl) expQ.delete();
         if (v && expRdy) expQ.push_back(model(f3, a, b, p, im));
      end
   endtask

   task automatic checkOutput();
      expT e;
      checks++;
      if (res_valid !== (expQ.size() != 0)) begin
         failures++;
         $display("[TB] FAIL res_valid: got %b, expected %b at %0t", res_valid, (expQ.size() != 0), $time);
      end
`ifdef BRANCH_STATS_EN
      checks++;
      if (cnt_taken !== modelTaken || cnt_not_taken !== modelNotTaken) begin
         failures++;
         $display("[TB] FAIL counters: got taken=%0d not_taken=%0d, expected taken=%0d not_taken=%0d",
                  cnt_taken, cnt_not_taken, modelTaken, modelNotTaken);
      end
`endif
      if (res_valid === 1'b1 && expQ.size() != 0) begin
         e = expQ[0];
         checks++;
         if ({res_taken, res_illegal, res_misalign, res_pc} !== {e.taken, e.illegal, e.misalign, e.pc}) begin
            failures++;
            $display("[TB] FAIL result: got taken=%b ill=%b mis=%b pc=%h, expected taken=%b ill=%b mis=%b pc=%h at %0t",
                     res_taken, res_illegal, res_misalign, res_pc, e.taken, e.illegal, e.misalign, e.pc, $time);
         end
         if (res_ready === 1'b1) begin
            void'(expQ.pop_front());
`ifdef BRANCH_STATS_EN
            if (flush !== 1'b1) begin
               if (e.taken) modelTaken++;
               else modelNotTaken++;
            end
`endif
         end
      end
   endtask

   // Monitor: compares the held result every cycle and retires it on handshake
   always @(negedge clk) checkOutput();

   task automatic checkResetState();
      checks++;
      if ({res_valid, res_taken, res_illegal, res_misalign, res_pc, in_ready} !== {5'b00000, 32'd0, 1'b1}) begin
         failures++;
         $display("[TB] FAIL reset_state: got valid=%b taken=%b ill=%b mis=%b pc=%h rdy=%b, expected all zero and rdy=1",
                  res_valid, res_taken, res_illegal, res_misalign, res_pc, in_ready);
      end
   endtask

   task automatic randomCycle();
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [31:0] im;
      a = $urandom;
      case ($urandom_range(0, 3))
         0:       b = a;
         1:       b = $urandom;
         2:       b = a ^ 32'h8000_0000;
         default: b = a + 32'd1;
      endcase
      r = $urandom;
      if ($urandom_range(0, 7) == 0) im = $urandom;
      else im = {{19{r[12]}}, r[12:1], 1'b0};
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b,
                    $urandom & 32'hFFFF_FFFC, im, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks   = 0;
      failures = 0;
`ifdef BRANCH_STATS_EN
      modelTaken    = 0;
      modelNotTaken = 0;
`endif
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
      funct3 = 3'd0; rs1_val = '0; rs2_val = '0; pc = '0; imm = '0;

      applyStimulus(1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      checkResetState();

      // Directed: BEQ, signed vs unsigned compare, illegal, wrap and misalign
      applyStimulus(1'b1, 3'b000, 32'h0000ABCD, 32'h0000ABCD, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'b100, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'b110, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'b010, 32'h5, 32'h5, 32'h300, 32'h8, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'b011, 32'h5, 32'h6, 32'h304, 32'h8, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'b001, 32'h1, 32'h2, 32'hFFFFFFF0, 32'h20, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'b001, 32'h1, 32'h2, 32'hFFFFFFF0, 32'h22, 1'b1, 1'b0, 1'b0);

      // Backpressure: three stalled cycles, then back-to-back draining
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 3'b101, 32'h10 + i, 32'h10, 32'h400, 32'h10, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 3'b111, 32'h20, 32'h1F + i, 32'h500 + 32'(4 * i), 32'hFFFFFFF8, 1'b1, 1'b0, 1'b0);

      // Flush while holding a result with a request pending
      applyStimulus(1'b1, 3'b000, 32'h7, 32'h7, 32'h600, 32'h4, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'b000, 32'h8, 32'h8, 32'h700, 32'h4, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 300; i++) randomCycle();

      // Reset mid-stream with a result in flight
      applyStimulus(1'b1, 3'b000, 32'h3, 32'h3, 32'h800, 32'h8, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b000, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 3'b000, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      checkResetState();

      for (int i = 0; i < 100; i++) randomCycle();
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 3'b000, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
